// File: rtl/elastic_pipe_reg.sv
// Two-entry skid-buffer stage register with flush, NOP-forcing of
// control bits and a saturating back-pressure counter.
module elastic_pipe_reg #(
  parameter int WIDTH  = 128,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              clr_stats,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] HALF  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              main_v_q, main_v_d;
  logic [WIDTH-1:0]  main_d_q, main_d_d;
  logic [CTRL_W-1:0] main_c_q, main_c_d;
  logic              skid_v_q, skid_v_d;
  logic [WIDTH-1:0]  skid_d_q, skid_d_d;
  logic [CTRL_W-1:0] skid_c_q, skid_c_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic in_fire;
  logic out_fire;

  assign in_ready  = (state_q != FULL);
  assign out_valid = main_v_q;
  assign out_data  = main_d_q;
  assign out_ctrl  = main_c_q;
  assign occupancy = state_q;
  assign stall_cnt = cnt_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d  = state_q;
    main_v_d = main_v_q;
    main_d_d = main_d_q;
    main_c_d = main_c_q;
    skid_v_d = skid_v_q;
    skid_d_d = skid_d_q;
    skid_c_d = skid_c_q;
    if (flush) begin
      // Data is left in place; only valid and ctrl define a NOP
      state_d  = EMPTY;
      main_v_d = 1'b0;
      main_c_d = '0;
      skid_v_d = 1'b0;
      skid_c_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_valid) begin
            main_v_d = 1'b1;
            main_d_d = in_data;
            main_c_d = in_ctrl;
            state_d  = HALF;
          end
        end
        HALF: begin
          if (in_fire) begin
            if (out_fire) begin
              main_d_d = in_data;
              main_c_d = in_ctrl;
            end else begin
              skid_v_d = 1'b1;
              skid_d_d = in_data;
              skid_c_d = in_ctrl;
              state_d  = FULL;
            end
          end else if (out_fire) begin
            main_v_d = 1'b0;
            main_c_d = '0;
            state_d  = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_v_d = skid_v_q;
            main_d_d = skid_d_q;
            main_c_d = skid_c_q;
            skid_v_d = 1'b0;
            skid_c_d = '0;
            state_d  = HALF;
          end
        end
        default: begin
          state_d  = EMPTY;
          main_v_d = 1'b0;
          main_c_d = '0;
          skid_v_d = 1'b0;
          skid_c_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_stats)
      cnt_d = '0;
    else if (out_valid && !out_ready && !(&cnt_q))
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= EMPTY;
      main_v_q <= 1'b0;
      main_d_q <= '0;
      main_c_q <= '0;
      skid_v_q <= 1'b0;
      skid_d_q <= '0;
      skid_c_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      main_v_q <= main_v_d;
      main_d_q <= main_d_d;
      main_c_q <= main_c_d;
      skid_v_q <= skid_v_d;
      skid_d_q <= skid_d_d;
      skid_c_q <= skid_c_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Directed bench for elastic_pipe_reg: vector table plus
// hand sequences for reset, streaming, back-pressure, saturation.
module tb_elastic_pipe_reg;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         clr_stats;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [7:0]   in_ctrl;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [7:0]   out_ctrl;
  logic [1:0]   occupancy;
  logic [3:0]   stall_cnt;

  int total;
  int bad;

  elastic_pipe_reg #(
    .WIDTH (128),
    .CTRL_W(8),
    .CNT_W (4)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .clr_stats(clr_stats),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic [7:0]  c;
    logic        ordy;
    logic        fl;
    logic        clr;
    logic        e_v;
    logic [31:0] e_d;
    logic [7:0]  e_c;
    logic [1:0]  e_occ;
    logic        e_rdy;
    logic [3:0]  e_st;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [127:0] pk(input logic [31:0] x);
    return {4{x}};
  endfunction

  task automatic chk(input string n, input logic [159:0] a,
                     input logic [159:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] d,
                       input logic [7:0] c, input logic ordy);
    in_valid  = iv;
    in_data   = pk(d);
    in_ctrl   = c;
    out_ready = ordy;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    vecs[0]  = '{1, 32'hA1, 8'h11, 1, 0, 0, 1, 32'hA1, 8'h11, 1, 1, 0};
    vecs[1]  = '{1, 32'hA2, 8'h12, 1, 0, 0, 1, 32'hA2, 8'h12, 1, 1, 0};
    vecs[2]  = '{1, 32'hA3, 8'h13, 0, 0, 0, 1, 32'hA2, 8'h12, 2, 0, 1};
    vecs[3]  = '{1, 32'hA4, 8'h14, 0, 0, 0, 1, 32'hA2, 8'h12, 2, 0, 2};
    vecs[4]  = '{0, 32'h0,  8'h00, 1, 0, 0, 1, 32'hA3, 8'h13, 1, 1, 2};
    vecs[5]  = '{0, 32'h0,  8'h00, 1, 0, 0, 0, 32'hA3, 8'h00, 0, 1, 2};
    vecs[6]  = '{0, 32'h0,  8'h00, 0, 0, 0, 0, 32'hA3, 8'h00, 0, 1, 2};
    vecs[7]  = '{1, 32'hB1, 8'hFF, 0, 0, 0, 1, 32'hB1, 8'hFF, 1, 1, 2};
    vecs[8]  = '{1, 32'hB2, 8'h81, 0, 0, 0, 1, 32'hB1, 8'hFF, 2, 0, 3};
    vecs[9]  = '{1, 32'hB3, 8'h77, 0, 1, 0, 0, 32'hB1, 8'h00, 0, 1, 4};
    vecs[10] = '{0, 32'h0,  8'h00, 1, 0, 1, 0, 32'hB1, 8'h00, 0, 1, 0};
    vecs[11] = '{1, 32'hC1, 8'h21, 1, 1, 1, 0, 32'hB1, 8'h00, 0, 1, 0};
    vecs[12] = '{1, 32'hC2, 8'h22, 1, 0, 0, 1, 32'hC2, 8'h22, 1, 1, 0};
    vecs[13] = '{0, 32'h0,  8'h00, 1, 0, 0, 0, 32'hC2, 8'h00, 0, 1, 0};

    // Reset with a packet already offered
    rst       = 1'b0;
    flush     = 1'b0;
    clr_stats = 1'b0;
    drive(1, 32'h123456AB, 8'h5A, 1);
    #1;
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_stall", stall_cnt, 4'd0);
    step();
    step();
    rst = 1'b1;
    chk("rel_ready", in_ready, 1'b1);
    chk("rel_valid", out_valid, 1'b0);
    step();
    chk("first_valid", out_valid, 1'b1);
    chk("first_data", out_data, pk(32'h123456AB));
    chk("first_ctrl", out_ctrl, 8'h5A);
    chk("first_occ", occupancy, 2'd1);
    drive(0, 32'h0, 8'h00, 1);
    step();
    chk("first_drain", occupancy, 2'd0);

    // Streaming 100 packets
    for (int i = 0; i < 100; i++) begin
      drive(1, 32'h1000 + i, i[7:0], 1);
      step();
      chk("stream_vr", {out_valid, in_ready}, 2'b11);
      chk("stream_data", out_data, pk(32'h1000 + i));
    end
    drive(0, 32'h0, 8'h00, 1);
    step();
    chk("stream_stall", stall_cnt, 4'd0);
    chk("stream_occ", occupancy, 2'd0);

    // Vector table
    for (int k = 0; k < 14; k++) begin
      drive(vecs[k].iv, vecs[k].d, vecs[k].c, vecs[k].ordy);
      flush     = vecs[k].fl;
      clr_stats = vecs[k].clr;
      step();
      chk($sformatf("v%0d_valid", k), out_valid, vecs[k].e_v);
      chk($sformatf("v%0d_data", k), out_data, pk(vecs[k].e_d));
      chk($sformatf("v%0d_ctrl", k), out_ctrl, vecs[k].e_c);
      chk($sformatf("v%0d_occ", k), occupancy, vecs[k].e_occ);
      chk($sformatf("v%0d_ready", k), in_ready, vecs[k].e_rdy);
      chk($sformatf("v%0d_stall", k), stall_cnt, vecs[k].e_st);
    end
    flush     = 1'b0;
    clr_stats = 1'b0;

    // Back-pressure: D0, D1 captured, D2 refused
    drive(1, 32'hD0, 8'h01, 0);
    step();
    drive(1, 32'hD1, 8'h02, 0);
    step();
    chk("bp_occ2", occupancy, 2'd2);
    chk("bp_ready0", in_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'hD2, 8'h03, 0);
      step();
    end
    chk("bp_stall5", stall_cnt, 4'd5);
    chk("bp_hold_d0", out_data, pk(32'hD0));
    drive(1, 32'hD2, 8'h03, 1);
    step();
    chk("bp_out_d1", {out_valid, out_data}, {1'b1, pk(32'hD1)});
    chk("bp_occ1", occupancy, 2'd1);
    step();
    chk("bp_out_d2", {out_valid, out_data}, {1'b1, pk(32'hD2)});
    chk("bp_ctrl_d2", out_ctrl, 8'h03);
    drive(0, 32'h0, 8'h00, 1);
    step();
    chk("bp_empty", {out_valid, occupancy}, 3'b000);
    chk("bp_stall_keep", stall_cnt, 4'd5);

    // Saturation and clear
    clr_stats = 1'b1;
    drive(1, 32'hE0, 8'h0E, 0);
    step();
    chk("sat_clr0", stall_cnt, 4'd0);
    clr_stats = 1'b0;
    drive(0, 32'h0, 8'h00, 0);
    for (int i = 0; i < 20; i++) step();
    chk("sat_15", stall_cnt, 4'd15);
    clr_stats = 1'b1;
    step();
    chk("sat_clear", stall_cnt, 4'd0);
    clr_stats = 1'b0;
    step();
    chk("sat_resume", stall_cnt, 4'd1);

    // Asynchronous reset while FULL
    drive(1, 32'hF1, 8'hF1, 0);
    step();
    chk("ar_full", occupancy, 2'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_valid", out_valid, 1'b0);
    chk("ar_occ", occupancy, 2'd0);
    chk("ar_ready", in_ready, 1'b1);
    chk("ar_ctrl", out_ctrl, 8'h00);
    chk("ar_stall", stall_cnt, 4'd0);
    drive(0, 32'h0, 8'h00, 1);
    #1;
    rst = 1'b1;
    step();
    chk("ar_post_empty", {out_valid, occupancy}, 3'b000);
    drive(1, 32'hF2, 8'h2F, 1);
    step();
    chk("ar_post_pkt", {out_valid, out_data}, {1'b1, pk(32'hF2)});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/elastic_pipe_reg.md
# elastic_pipe_reg

Parametrised, handshaked successor to the fixed-width flush/enable stage registers between pipeline stages (IF/ID, ID/EX, EX/MEM). It carries one packet made of a data payload and a control field (WB_enable, mem_read, mem_write, B, S and similar) through a two-entry skid buffer. Back-pressure from the downstream stage never creates a combinational path to the upstream stage. Flush turns every held entry into a NOP by clearing its valid and control bits.

## Interface
- WIDTH, 128: payload width in bits (PC, Val_Rn, Val_Rm, immediates, register indices, packed).
- CTRL_W, 8: control-field width; these bits are forced to 0 for any flushed or empty entry.
- CNT_W, 16: stall-counter width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous kill of all held entries
- clr_stats  in  1  synchronous clear of stall_cnt
- in_valid  in  1  upstream has a packet
- in_ready  out  1  this stage can accept a packet
- in_data  in  WIDTH  upstream payload
- in_ctrl  in  CTRL_W  upstream control bits
- out_valid  out  1  output packet valid
- out_ready  in  1  downstream accepts the packet
- out_data  out  WIDTH  output payload
- out_ctrl  out  CTRL_W  output control bits; 0 whenever out_valid=0
- occupancy  out  2  number of held entries (0..2)
- stall_cnt  out  CNT_W  saturating count of back-pressured cycles

## Operation
- Storage is a main entry (drives the out_* ports) and a skid entry. Each entry has a valid flag, data and ctrl.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- State is encoded by occupancy: EMPTY=0, HALF=1, FULL=2.
- in_ready = (state != FULL), decoded from flops only.
- EMPTY: in_valid → main <= in, go to HALF. Otherwise stay EMPTY.
- HALF, per cycle:
  - in_fire and out_fire → main <= in, stay HALF.
  - in_fire only → skid <= in, go to FULL.
  - out_fire only → go to EMPTY; clear main ctrl.
  - neither → hold.
- FULL: in_ready=0. out_fire → main <= skid, clear skid ctrl, go to HALF. Otherwise hold.
- Packets leave in exactly the order they were accepted. None is dropped or duplicated except by flush.
- Flush (highest priority after reset):
  - next state is EMPTY; both valids and both ctrl fields become 0; data fields keep their values.
  - any in_fire in the flush cycle is discarded.
  - an out_fire in the flush cycle counts as consumed downstream; the downstream stage owns that decision.
- stall_cnt: +1 each cycle that out_valid=1 and out_ready=0. Saturates at 2^CNT_W-1.
  - clr_stats sets it to 0 and has priority over the increment.
  - flush does not clear it.
- Reset (rst=0), asynchronous: all valids, data, ctrl, occupancy and stall_cnt go to 0. On reset release in_ready=1 and out_valid=0.
- Reset asserted mid-transfer drops every held packet immediately, with no clock needed.

## Timing
- Latency from in_fire to out_valid is 1 cycle when the stage is EMPTY or HALF-and-draining.
- Sustained throughput is 1 packet/cycle while out_ready=1.
- All outputs come straight from flops. There is no combinational path from out_ready or in_valid to in_ready, out_valid or out_data.
- in_ready falls in the cycle after the second entry is captured. It rises in the cycle after the first out_fire from FULL.
- Data lost to back-pressure: none. One cycle of late in_ready is absorbed by the skid entry.
- Flush effect is visible on outputs in the cycle after flush is sampled high: out_valid=0, out_ctrl=0, occupancy=0, in_ready=1.
- Simultaneous flush and clr_stats: both take effect in the same cycle.

## Test plan
- Reset and single packet:
  - rst low then released, with in_valid=1, in_data=0x...AB, in_ctrl=0x5A, out_ready=1.
  - Required: in_ready=1 and out_valid=0 in the first cycle. Next cycle out_valid=1, out_data=0x...AB, out_ctrl=0x5A, occupancy=1.
- Streaming:
  - 100 packets back-to-back with incrementing data, out_ready=1.
  - Required: in_ready stays 1; outputs are in order at 1/cycle with 1 cycle of latency; stall_cnt=0.
- Back-pressure:
  - out_ready=0 for 5 cycles while in_valid=1 with packets D0, D1, D2, ….
  - Required: occupancy 1→2 and in_ready=0 after the second capture; stall_cnt=5; D2 is not accepted.
  - Then out_ready=1: the stage delivers D0, D1, D2 in order with no gap.
- Flush while FULL:
  - FULL holding ctrl 0xFF/0x81, with flush=1 and in_valid=1 in the same cycle.
  - Required next cycle: out_valid=0, out_ctrl=0, occupancy=0, in_ready=1. The input offered in the flush cycle never appears on the output.
- Saturation and clear:
  - CNT_W=4, out_valid held with out_ready=0 for 20 cycles.
  - Required: stall_cnt stops at 15. One cycle of clr_stats makes it 0, then it resumes counting.
- Asynchronous reset mid-stream:
  - rst pulsed low between clock edges while FULL.
  - Required: outputs clear immediately, without waiting for a clock edge. On release the stage behaves as empty.
